pll_cfg_seq: RTL and testbench

PLL_CFG_SEQ -- requirements
Module: pll_cfg_seq

---
 rtl/pll_cfg_seq.sv | 144 ++++++++++++++
 tb/tb_pll_cfg_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_cfg_seq.sv
// PLL configuration sequencer: takes a divider set, pulses the macro reset,
// waits for a qualified lock with timeout, and watches for lock loss afterwards.
module pll_cfg_seq #(
  parameter int unsigned LOCK_CYC   = 20'h1FFFF,
  parameter int unsigned RST_CYC    = 16,
  parameter int unsigned TO_CYC     = 20'hFFFFF,
  parameter int unsigned CNT_W      = 20,
  parameter bit          USE_LKDT   = 1'b1,
  parameter logic [7:0]  RST_REFDIV = '0,
  parameter logic [11:0] RST_FBDIV  = '0,
  parameter logic [3:0]  RST_PD1    = '0,
  parameter logic [1:0]  RST_PD2    = '0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [7:0]  cfg_refdiv_i,
  input  logic [11:0] cfg_fbdiv_i,
  input  logic [3:0]  cfg_postdiv1_i,
  input  logic [1:0]  cfg_postdiv2_i,
  input  logic        cfg_bp_i,
  input  logic        pll_lkdt_i,
  output logic        pll_rst_o,
  output logic [7:0]  pll_refdiv_o,
  output logic [11:0] pll_fbdiv_o,
  output logic [3:0]  pll_postdiv1_o,
  output logic [1:0]  pll_postdiv2_o,
  output logic        pll_bp_o,
  output logic        lock_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        lost_o
);

  typedef enum logic [2:0] {BYP, PRST, WLOCK, LOCKED, FAIL} state_t;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [CNT_W-1:0] to_q, to_nxt;
  logic [1:0]       sync_q;
  logic             lkdt_s;
  logic             accept;
  logic             lost_set;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign lkdt_s = USE_LKDT ? sync_q[1] : 1'b1;
  assign accept = cfg_valid_i & cfg_ready_o;

  // cnt_q times the reset pulse in PRST and the qualified-lock run in WLOCK.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = sat_inc(cnt_q);
    to_nxt    = sat_inc(to_q);
    lost_set  = 1'b0;
    unique case (state_q)
      PRST: begin
        to_nxt = '0;
        if (cnt_q == RST_LAST) begin
          state_nxt = WLOCK;
          cnt_nxt   = '0;
        end
      end
      WLOCK: begin
        if (!lkdt_s) cnt_nxt = '0;
        if (lkdt_s && cnt_q == LOCK_LAST) begin
          state_nxt = LOCKED;
          cnt_nxt   = '0;
          to_nxt    = '0;
        end else if (to_q == TO_LAST) begin
          state_nxt = FAIL;
          cnt_nxt   = '0;
          to_nxt    = '0;
        end
      end
      LOCKED: begin
        cnt_nxt = '0;
        to_nxt  = '0;
        if (!lkdt_s) begin
          state_nxt = WLOCK;
          lost_set  = 1'b1;
        end
      end
      default: begin
        cnt_nxt = '0;
        to_nxt  = '0;
      end
    endcase
    // A new config overrides whatever the current state wanted, including lock loss.
    if (accept) begin
      state_nxt = cfg_bp_i ? BYP : PRST;
      cnt_nxt   = '0;
      to_nxt    = '0;
      lost_set  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= BYP;
      cnt_q          <= '0;
      to_q           <= '0;
      sync_q         <= '0;
      cfg_ready_o    <= 1'b1;
      pll_rst_o      <= 1'b1;
      pll_bp_o       <= 1'b1;
      lock_o         <= 1'b0;
      busy_o         <= 1'b0;
      err_o          <= 1'b0;
      lost_o         <= 1'b0;
      pll_refdiv_o   <= RST_REFDIV;
      pll_fbdiv_o    <= RST_FBDIV;
      pll_postdiv1_o <= RST_PD1;
      pll_postdiv2_o <= RST_PD2;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      to_q        <= to_nxt;
      sync_q      <= {sync_q[0], pll_lkdt_i};
      cfg_ready_o <= state_nxt inside {BYP, LOCKED, FAIL};
      pll_rst_o   <= state_nxt inside {BYP, PRST, FAIL};
      pll_bp_o    <= (state_nxt != LOCKED);
      lock_o      <= (state_nxt == LOCKED);
      busy_o      <= state_nxt inside {PRST, WLOCK};
      err_o       <= (state_nxt == FAIL);
      lost_o      <= lost_set | (lost_o & ~accept);
      if (accept) begin
        pll_refdiv_o   <= cfg_refdiv_i;
        pll_fbdiv_o    <= cfg_fbdiv_i;
        pll_postdiv1_o <= cfg_postdiv1_i;
        pll_postdiv2_o <= cfg_postdiv2_i;
      end
    end
  end

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Bench for pll_cfg_seq: directed scenarios plus a random run, all checked against
// a timestamp-based behavioural model of the sequencer.
module tb_pll_cfg_seq;
  localparam int LC = 8, RC = 4, TC = 32;
  localparam int M_BYP = 0, M_PRST = 1, M_WLOCK = 2, M_LOCKED = 3, M_FAIL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0, cfg_valid = 1'b0, bp = 1'b0, lkdt = 1'b0;
  logic [7:0] refdiv = '0;
  logic [11:0] fbdiv = '0;
  logic [3:0] pd1 = '0;
  logic [1:0] pd2 = '0;

  logic d_ready, d_rst, d_bp, d_lock, d_busy, d_err, d_lost;
  logic [7:0] d_ref; logic [11:0] d_fb; logic [3:0] d_pd1; logic [1:0] d_pd2;
  logic c_ready, c_rst, c_bp, c_lock, c_busy, c_err, c_lost;
  logic [7:0] c_ref; logic [11:0] c_fb; logic [3:0] c_pd1; logic [1:0] c_pd2;

  logic [6:0]  d_flags, c_flags;
  logic [25:0] d_div;
  assign d_flags = {d_ready, d_rst, d_bp, d_lock, d_busy, d_err, d_lost};
  assign c_flags = {c_ready, c_rst, c_bp, c_lock, c_busy, c_err, c_lost};
  assign d_div   = {d_ref, d_fb, d_pd1, d_pd2};

  int checks = 0, failures = 0;

  pll_cfg_seq #(.LOCK_CYC(LC), .RST_CYC(RC), .TO_CYC(TC), .CNT_W(20), .USE_LKDT(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(d_ready),
    .cfg_refdiv_i(refdiv), .cfg_fbdiv_i(fbdiv), .cfg_postdiv1_i(pd1), .cfg_postdiv2_i(pd2),
    .cfg_bp_i(bp), .pll_lkdt_i(lkdt), .pll_rst_o(d_rst), .pll_refdiv_o(d_ref),
    .pll_fbdiv_o(d_fb), .pll_postdiv1_o(d_pd1), .pll_postdiv2_o(d_pd2), .pll_bp_o(d_bp),
    .lock_o(d_lock), .busy_o(d_busy), .err_o(d_err), .lost_o(d_lost));

  pll_cfg_seq #(.LOCK_CYC(LC), .RST_CYC(RC), .TO_CYC(TC), .CNT_W(20), .USE_LKDT(1'b0)) u_cnt (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(c_ready),
    .cfg_refdiv_i(refdiv), .cfg_fbdiv_i(fbdiv), .cfg_postdiv1_i(pd1), .cfg_postdiv2_i(pd2),
    .cfg_bp_i(bp), .pll_lkdt_i(lkdt), .pll_rst_o(c_rst), .pll_refdiv_o(c_ref),
    .pll_fbdiv_o(c_fb), .pll_postdiv1_o(c_pd1), .pll_postdiv2_o(c_pd2), .pll_bp_o(c_bp),
    .lock_o(c_lock), .busy_o(c_busy), .err_o(c_err), .lost_o(c_lost));

  always #5 clk = ~clk;

  // Model: phases are timed from the edge they were entered, lock by a run length.
  int   m_mode = M_BYP, m_t = 0, m_run = 0, now = 0;
  logic m_lost = 1'b0, s1 = 1'b0, s2 = 1'b0;
  logic [7:0] m_ref = '0; logic [11:0] m_fb = '0; logic [3:0] m_pd1 = '0; logic [1:0] m_pd2 = '0;

  function automatic logic [6:0] m_flags();
    logic rdy;
    rdy = (m_mode == M_BYP) || (m_mode == M_LOCKED) || (m_mode == M_FAIL);
    return {rdy, (m_mode == M_BYP) || (m_mode == M_PRST) || (m_mode == M_FAIL),
            m_mode != M_LOCKED, m_mode == M_LOCKED,
            (m_mode == M_PRST) || (m_mode == M_WLOCK), m_mode == M_FAIL, m_lost};
  endfunction

  task automatic model_step();
    logic ls, acc;
    ls  = s2;
    acc = cfg_valid && ((m_mode == M_BYP) || (m_mode == M_LOCKED) || (m_mode == M_FAIL));
    now++;
    if (rst) begin
      m_mode = M_BYP; m_lost = 1'b0; m_run = 0; s1 = 1'b0; s2 = 1'b0;
      m_ref = '0; m_fb = '0; m_pd1 = '0; m_pd2 = '0;
    end else begin
      s2 = s1; s1 = lkdt;
      if (acc) begin
        m_ref = refdiv; m_fb = fbdiv; m_pd1 = pd1; m_pd2 = pd2;
        m_lost = 1'b0; m_mode = bp ? M_BYP : M_PRST; m_t = now;
      end else begin
        case (m_mode)
          M_PRST: if (now - m_t == RC) begin m_mode = M_WLOCK; m_t = now; m_run = 0; end
          M_WLOCK: begin
            m_run = ls ? m_run + 1 : 0;
            if (m_run == LC) m_mode = M_LOCKED;
            else if (now - m_t == TC) m_mode = M_FAIL;
          end
          M_LOCKED: if (!ls) begin m_mode = M_WLOCK; m_t = now; m_run = 0; m_lost = 1'b1; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk({tag, ".flags"}, 32'(d_flags), 32'(m_flags()));
    chk({tag, ".div"}, 32'(d_div), 32'({m_ref, m_fb, m_pd1, m_pd2}));
  endtask

  initial begin
    int hold, changes;
    logic [25:0] prev;

    // reset
    rst = 1'b1;
    tick("rst"); tick("rst");
    chk("rst_state", 32'(d_flags), 32'(7'b1110000));
    chk("rst_state_cnt", 32'(c_flags), 32'(7'b1110000));
    rst = 1'b0;

    // count-only lock on u_cnt, timeout on u_dut with lock-detect held low
    lkdt = 1'b0; bp = 1'b0; refdiv = 8'd1; fbdiv = 12'd40; pd1 = 4'd2; pd2 = 2'd1;
    cfg_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick("seq40");
      cfg_valid = 1'b0;
      chk("cnt_rst", 32'(c_rst), 32'(k < 4));
      chk("cnt_lock", 32'(c_lock), 32'(k >= 12));
      chk("cnt_bp", 32'(c_bp), 32'(k < 12));
      chk("cnt_div", 32'({c_ref, c_fb}), 32'({8'd1, 12'd40}));
      chk("to_err", 32'(d_err), 32'(k >= 36));
      chk("to_ready", 32'(d_ready), 32'(k >= 36 || k == -1));
      chk("to_nolock", 32'(d_lock), 32'd0);
    end

    // lock, then lose it for three cycles
    lkdt = 1'b1; refdiv = 8'd3; fbdiv = 12'd77; cfg_valid = 1'b1;
    tick("acc_c"); cfg_valid = 1'b0;
    for (int k = 0; k < 15; k++) tick("lock_c");
    chk("locked_c", 32'(d_lock), 32'd1);
    lkdt = 1'b0;
    tick("drop0"); chk("drop0_lock", 32'(d_lock), 32'd1);
    tick("drop1"); chk("drop1_lock", 32'(d_lock), 32'd1);
    tick("drop2"); chk("drop2_lock", 32'(d_lock), 32'd0); chk("drop2_lost", 32'(d_lost), 32'd1);
    lkdt = 1'b1;
    for (int j = 3; j <= 13; j++) begin
      tick("relock");
      chk("relock_lock", 32'(d_lock), 32'(j >= 12));
      chk("relock_lost", 32'(d_lost), 32'd1);
    end

    // bypass request
    bp = 1'b1; cfg_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick("byp");
      cfg_valid = 1'b0;
      chk("byp_busy", 32'(d_busy), 32'd0);
      chk("byp_out", 32'({d_bp, d_rst, d_lock}), 32'(3'b110));
    end
    bp = 1'b0;

    // reset mid-WLOCK, then a clean 12-cycle sequence
    lkdt = 1'b0; refdiv = 8'h5A; cfg_valid = 1'b1;
    tick("acc_e"); cfg_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick("wl_e");
    rst = 1'b1;
    tick("rst_mid");
    chk("rst_mid_flags", 32'(d_flags), 32'(7'b1110000));
    chk("rst_mid_div", 32'(d_div), 32'd0);
    rst = 1'b0; lkdt = 1'b1;
    tick("idle"); tick("idle");
    refdiv = 8'h11; fbdiv = 12'h222; cfg_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick("seq_e");
      cfg_valid = 1'b0;
      chk("seq_e_rst", 32'(d_rst), 32'(k < 4));
      chk("seq_e_lock", 32'(d_lock), 32'(k >= 12));
    end

    // acceptance coinciding with lock loss
    lkdt = 1'b0;
    tick("co0"); tick("co1");
    cfg_valid = 1'b1; refdiv = 8'h66;
    tick("co2");
    cfg_valid = 1'b0; lkdt = 1'b1;
    chk("co_lost", 32'(d_lost), 32'd0);
    chk("co_busy", 32'(d_busy), 32'd1);
    for (int k = 0; k < 16; k++) tick("co_lock");

    // valid held with changing data: accepts only from LOCKED
    changes = 0; prev = d_div;
    cfg_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      refdiv = 8'(i + 100); fbdiv = 12'($urandom); pd1 = 4'($urandom); pd2 = 2'($urandom);
      tick("hold");
      if (d_div !== prev) changes++;
      prev = d_div;
    end
    chk("hold_accepts", 32'(changes), 32'd3);
    cfg_valid = 1'b0;

    // random run
    hold = 10;
    for (int i = 0; i < 2000; i++) begin
      if (hold == 0) begin
        lkdt = ~lkdt;
        hold = lkdt ? int'($urandom_range(60, 1)) : int'($urandom_range(8, 1));
      end
      hold--;
      cfg_valid = ($urandom_range(7, 0) == 0);
      bp        = ($urandom_range(5, 0) == 0);
      rst       = ($urandom_range(199, 0) == 0);
      refdiv = 8'($urandom); fbdiv = 12'($urandom); pd1 = 4'($urandom); pd2 = 2'($urandom);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
